// File: rtl/serial_load_ctrl.sv
// serial_load_ctrl: assembles a framed serial bitstream into a WIDTH-bit word.
// The word is presented on dout with a one-cycle load strobe for a downstream
// bank of loadable register cells.
//
// Parameters:
//   WIDTH     - data bits per frame and the width of dout (2..32)
//   MSB_FIRST - 1: the first received bit lands in dout[WIDTH-1]
//               0: the first received bit lands in dout[0]
//
// Ports:
//   clk       - system clock, rising edge
//   arst      - synchronous active-high reset
//   start     - frame start strobe (acts as a restart while a frame is open)
//   din       - serial data bit
//   din_valid - din is sampled in cycles where this is 1
//   dout      - assembled word, held between loads
//   load      - one-cycle strobe, dout is new in this cycle
//   busy      - 1 whenever the controller is not idle
//   abort     - one-cycle pulse when a frame is abandoned by a restart
//   perr      - one-cycle parity error pulse (constant 0 without parity)
//
// Optional feature macro: SERIAL_LOAD_PARITY_EN
//   When defined, an even-parity bit follows the WIDTH data bits. A parity
//   mismatch pulses perr, suppresses load and leaves dout unchanged.
//   All outputs are registered.

module serial_load_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             load,
  output logic             busy,
  output logic             abort,
  output logic             perr
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SERIAL_LOAD_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_LOAD   = 2'd2,
    S_PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LOAD  = 2'd2
  } state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shift_nxt;
  logic             last_bit;

  // Shift register contents after accepting the current din.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign shift_nxt = {sreg[WIDTH-2:0], din};
  end else begin : g_lsb_first
    assign shift_nxt = {din, sreg[WIDTH-1:1]};
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_LOAD_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  logic par_ok;
  assign par_ok = ~(^{sreg, din});
`else
  assign perr = 1'b0;
`endif

  // Frame controller; pulse outputs default low every cycle.
  always_ff @(posedge clk) begin
    if (arst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sreg  <= '0;
      dout  <= '0;
      load  <= 1'b0;
      busy  <= 1'b0;
      abort <= 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      load  <= 1'b0;
      abort <= 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
      perr  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SHIFT;
            cnt   <= '0;
            sreg  <= '0;
            busy  <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (start) begin
            // Restart: drop partial bits, stay in SHIFT, din not sampled.
            abort <= 1'b1;
            cnt   <= '0;
            sreg  <= '0;
          end else if (din_valid) begin
            sreg <= shift_nxt;
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
`ifdef SERIAL_LOAD_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_LOAD;
              dout  <= shift_nxt;
              load  <= 1'b1;
`endif
            end
          end
        end

`ifdef SERIAL_LOAD_PARITY_EN
        S_PARITY: begin
          if (start) begin
            state <= S_SHIFT;
            abort <= 1'b1;
            cnt   <= '0;
            sreg  <= '0;
          end else if (din_valid) begin
            if (par_ok) begin
              state <= S_LOAD;
              dout  <= sreg;
              load  <= 1'b1;
            end else begin
              state <= S_IDLE;
              perr  <= 1'b1;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end
        end
`endif

        S_LOAD: begin
          // Back-to-back frames: start in the load cycle opens the next one.
          cnt  <= '0;
          sreg <= '0;
          if (start) begin
            state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_load_ctrl.md
Name: serial_load_ctrl

Overview:
- Serial-to-parallel front end that feeds a bank of WIDTH loadable D flip-flop cells.
- Assembles a framed serial bitstream into a WIDTH-bit word.
- Presents the word on `dout` with a one-cycle `load` strobe, wired to the `load`/`din` inputs of the downstream register cells.
- Sits directly upstream of the register bank; the downstream cells capture `dout` on the clock edge where `load`=1.

Parameters:
- WIDTH, 8: data bits per frame, and the width of `dout`; legal values 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in `dout[WIDTH-1]`; 0 = first received bit lands in `dout[0]`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- arst  in  1  reset, synchronous, active-high; sampled on the `clk` rising edge.
- start  in  1  frame start strobe, one cycle.
- din  in  1  serial data bit.
- din_valid  in  1  `din` is sampled in cycles where this is 1.
- dout  out  WIDTH  assembled parallel word; held between loads.
- load  out  1  one-cycle strobe; `dout` is valid and new in this cycle.
- busy  out  1  1 whenever state != IDLE.
- abort  out  1  one-cycle pulse when a frame is abandoned by a restart.
- perr  out  1  parity error pulse (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Reset (`arst`=1 at a rising edge):
  - state=IDLE, bit counter=0, shift register=0.
  - dout=0, load=0, busy=0, abort=0, perr=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-frame discards all partial bits and issues no `load`.
- All outputs are registered.
- IDLE:
  - `din`/`din_valid` are ignored.
  - `start`=1 -> go to SHIFT with counter=0.
  - The `start` cycle never samples `din`, even if `din_valid`=1.
- SHIFT:
  - Each cycle with `din_valid`=1 shifts `din` into the shift register and increments the counter.
  - Cycles with `din_valid`=0 hold all state; gaps of any length are allowed.
  - Shift direction: MSB_FIRST=1 shifts left with the new bit at [0]; MSB_FIRST=0 shifts right with the new bit at [WIDTH-1].
  - When the WIDTH-th valid bit is sampled, go to LOAD (or PARITY when enabled).
- LOAD (exactly one cycle):
  - `load`=1; `dout` is updated to the assembled word in the same cycle.
  - Next state is IDLE, or SHIFT if `start`=1 in this cycle (back-to-back frames; `start` is honoured, not lost).
- Latency: `load` rises in the cycle after the edge that sampled the last data bit.
- Restart: `start`=1 during SHIFT:
  - `abort` pulses in the next cycle.
  - Counter and shift register clear; state stays SHIFT.
  - `dout` is unchanged and no `load` is issued.
  - The same cycle's `din` is not sampled.
- `dout` changes only in the LOAD cycle or on reset.
- Counter width is clog2(WIDTH+1); it never exceeds WIDTH.

Optional Feature:
- Macro: SERIAL_LOAD_PARITY_EN.
- Defined:
  - After the WIDTH data bits, state PARITY samples one more valid bit as an even-parity bit (XOR of data and parity must be 0).
  - Parity OK -> LOAD as normal.
  - Mismatch -> `perr`=1 for one cycle, no `load`, `dout` unchanged, return to IDLE.
  - `start` in PARITY behaves as a restart (`abort` pulses).
  - `load` latency is one valid bit later than without the feature.
- Undefined: no PARITY state; `perr` is tied to 0.

Test Plan:
1. Reset: hold `arst`=1 for 2 cycles mid-frame (after 5 bits) -> dout=0x00, load=0, busy=0; then full frame 0x81 -> dout=0x81, one `load` pulse.
2. WIDTH=8, MSB_FIRST=1: `start`, then 8 consecutive valid bits 1,0,1,0,0,1,0,1 -> `load`=1 exactly one cycle after the 8th bit, dout=0xA5, busy=0 the cycle after `load`.
3. Gaps: frame 0xFF with `din_valid`=0 for 3 cycles after bit 4 -> no early `load`; `load` one cycle after the 8th valid bit, dout=0xFF.
4. Restart: `start`, 4 bits, `start` again, then 8 bits 0,0,1,1,1,1,0,0 -> one `abort` pulse, single `load`, dout=0x3C.
5. Bit order: bits 1,1,0,0,0,0,0,0 -> MSB_FIRST=1 gives dout=0xC0; MSB_FIRST=0 gives dout=0x03. `start` asserted in the LOAD cycle starts the next frame with no lost cycle.
6. SERIAL_LOAD_PARITY_EN defined: 0xA5 with parity bit 0 -> `load`, dout=0xA5; 0x3C with parity bit 1 -> `perr` pulse, no `load`, dout stays 0xA5.
